// File: rtl/phase_arbiter.sv
// phase_arbiter
// Round-robin, actuated phase scheduler for one intersection with four
// competing approaches (0 main, 1 secondary, 2 pedestrian, 3 turn arrow).
// Requests are latched into pending. The shared right-of-way is granted to one
// approach at a time. Every grant is followed by yellow and then an all-red
// clearance. Timing is counted in ticks of an internal free-running divider.
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-high reset
//   req        in   4  level requests per approach, synchronous to clk
//   green      out  4  green grant, one-hot or zero
//   yellow     out  4  yellow for the approach being cleared, one-hot or zero
//   all_red    out  1  high while in the all-red state
//   pending    out  4  latched, unserved requests
//   phase_idx  out  2  index of approach last/currently granted
//   tick       out  1  one-cycle strobe every FPGAFREQ cycles
module phase_arbiter #(
    parameter int FPGAFREQ    = 50_000_000,
    parameter int T_GREEN_MIN = 5,
    parameter int T_GREEN_MAX = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic       all_red,
    output logic [3:0] pending,
    output logic [1:0] phase_idx,
    output logic       tick
);

    localparam int SEC_MAX = (T_YELLOW > T_ALLRED) ? T_YELLOW : T_ALLRED;
    localparam int SW      = $clog2(SEC_MAX + 1);
    localparam int EW      = $clog2(T_GREEN_MAX + 1);
    localparam int EW1     = EW + 1;
    localparam int DW      = (FPGAFREQ > 1) ? $clog2(FPGAFREQ) : 1;

    localparam logic [DW-1:0] DIV_LAST    = DW'(FPGAFREQ - 1);
    localparam logic [SW-1:0] YELLOW_LOAD = SW'(T_YELLOW - 1);
    localparam logic [SW-1:0] ALLRED_LOAD = SW'(T_ALLRED - 1);
    localparam logic [EW-1:0] ELAPSED_MAX = EW'(T_GREEN_MAX);
    localparam logic [EW:0]   E_MIN       = EW1'(T_GREEN_MIN);
    localparam logic [EW:0]   E_MAX       = EW1'(T_GREEN_MAX);

    localparam logic [1:0] S_ALLRED = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;

    logic [1:0]    state;
    logic [SW-1:0] sec_cnt;
    logic [EW-1:0] elapsed;
    logic [DW-1:0] div;
    logic [DW-1:0] div_next;

    logic [1:0]    pick;
    logic [1:0]    cand;
    logic          pick_valid;
    logic          grant;
    logic [3:0]    grant_mask;
    logic [3:0]    own_mask;
    logic          competing;
    logic [EW:0]   e_next;
    logic [EW-1:0] elapsed_sat;
    logic          green_exit;

    // Divider wraps at FPGAFREQ-1. tick is registered from the next divider
    // value so that it is high exactly during the cycle where div is at its
    // last count.
    always_comb begin
        div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            div  <= div_next;
            tick <= (div_next == DIV_LAST);
        end
    end

    // Round-robin search: the loop runs from the farthest candidate down to the
    // nearest, so the nearest set bit after phase_idx is the last one written.
    // The fourth candidate wraps back to phase_idx itself.
    always_comb begin
        pick       = phase_idx;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = phase_idx + 2'(k);
            if (pending[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Green exit decision. e_next is one bit wider than elapsed so that the
    // comparison against the maximum still works after elapsed has saturated.
    always_comb begin
        grant       = tick && (state == S_ALLRED) && (sec_cnt == '0) && pick_valid;
        grant_mask  = grant ? (4'b0001 << pick) : 4'b0000;
        own_mask    = 4'b0001 << phase_idx;
        competing   = |(pending & ~own_mask);
        e_next      = {1'b0, elapsed} + 1'b1;
        elapsed_sat = (elapsed == ELAPSED_MAX) ? elapsed : elapsed + 1'b1;
        green_exit  = (e_next >= E_MIN) && competing &&
                      (!req[phase_idx] || (e_next >= E_MAX));
    end

    // Pending latch. The approach currently holding green cannot re-request.
    // The clear on grant wins over a set in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 4'b0000;
        end else begin
            pending <= (pending | (req & ~green)) & ~grant_mask;
        end
    end

    // Phase sequencer ALLRED -> GREEN -> YELLOW -> ALLRED. It advances only
    // on tick cycles, so every state lasts a whole number of ticks. When
    // nothing is pending, all-red idles with sec_cnt held at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_ALLRED;
            sec_cnt   <= ALLRED_LOAD;
            elapsed   <= '0;
            green     <= 4'b0000;
            yellow    <= 4'b0000;
            all_red   <= 1'b1;
            phase_idx <= 2'd3;
        end else if (tick) begin
            case (state)
                S_ALLRED: begin
                    if (sec_cnt != '0) begin
                        sec_cnt <= sec_cnt - 1'b1;
                    end else if (pick_valid) begin
                        state     <= S_GREEN;
                        phase_idx <= pick;
                        green     <= 4'b0001 << pick;
                        all_red   <= 1'b0;
                        elapsed   <= '0;
                    end
                end
                S_GREEN: begin
                    elapsed <= elapsed_sat;
                    if (green_exit) begin
                        state   <= S_YELLOW;
                        yellow  <= green;
                        green   <= 4'b0000;
                        sec_cnt <= YELLOW_LOAD;
                    end
                end
                S_YELLOW: begin
                    if (sec_cnt == '0) begin
                        state   <= S_ALLRED;
                        yellow  <= 4'b0000;
                        all_red <= 1'b1;
                        sec_cnt <= ALLRED_LOAD;
                    end else begin
                        sec_cnt <= sec_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= S_ALLRED;
                    green   <= 4'b0000;
                    yellow  <= 4'b0000;
                    all_red <= 1'b1;
                    sec_cnt <= ALLRED_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_arbiter.sv
// tb_phase_arbiter
// Directed bench for phase_arbiter with FPGAFREQ=4, MIN=2, MAX=5, YELLOW=1,
// ALLRED=1. A table of {request pulse, ticks to advance, expected outputs}
// drives the main sequence. Hand-written sequences cover the multi-cycle
// corners: round-robin from idle, maximum green, early release, and
// asynchronous reset.
module tb_phase_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] green;
    logic [3:0] yellow;
    logic       all_red;
    logic [3:0] pending;
    logic [1:0] phase_idx;
    logic       tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] rq;
        int         ticks;
        logic [3:0] g;
        logic [3:0] y;
        logic       ar;
        logic [3:0] p;
        logic [1:0] ph;
    } vec_t;

    vec_t vecs[20];

    phase_arbiter #(
        .FPGAFREQ   (4),
        .T_GREEN_MIN(2),
        .T_GREEN_MAX(5),
        .T_YELLOW   (1),
        .T_ALLRED   (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .green    (green),
        .yellow   (yellow),
        .all_red  (all_red),
        .pending  (pending),
        .phase_idx(phase_idx),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock edge, then settle 1 ns so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string name, input string field,
                          input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s %s got %b want %b", name, field, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eg,
                               input logic [3:0] ey, input logic ear,
                               input logic [3:0] ep, input logic [1:0] eph);
        check4(name, "green", green, eg);
        check4(name, "yellow", yellow, ey);
        check4(name, "all_red", {3'b000, all_red}, {3'b000, ear});
        check4(name, "pending", pending, ep);
        check4(name, "phase_idx", {2'b00, phase_idx}, {2'b00, eph});
    endtask

    // Advance until just past the next tick edge, with a bounded wait
    task automatic tickEdge();
        int n = 0;
        while (tick !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        if (n >= 10) begin
            checks++;
            errors++;
            $display("[TB] FAIL tick_wait got no tick want tick within 10 cycles");
        end
        step();
    endtask

    task automatic applyStimulus(input logic [3:0] rq, input int ticks);
        req = rq;
        step();
        req = 4'b0000;
        for (int t = 0; t < ticks; t++) tickEdge();
    endtask

    // Counts cycles from a freshly released reset until tick is seen
    task automatic checkFirstTick(input string name);
        int n = 0;
        while (tick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check4(name, "cycles_to_tick", 4'(n), 4'd3);
        step();
        check4(name, "tick_width", {3'b000, tick}, 4'b0000);
    endtask

    task automatic doReset();
        reset = 1'b1;
        req   = 4'b0000;
        repeat (3) step();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] ones;
        logic [3:0] oh;
        logic [3:0] ep;

        vecs[0]  = '{4'b0100,  0, 4'b0000, 4'b0000, 1'b1, 4'b0100, 2'd3};
        vecs[1]  = '{4'b0000,  1, 4'b0100, 4'b0000, 1'b0, 4'b0000, 2'd2};
        vecs[2]  = '{4'b0000,  1, 4'b0100, 4'b0000, 1'b0, 4'b0000, 2'd2};
        vecs[3]  = '{4'b0001,  0, 4'b0100, 4'b0000, 1'b0, 4'b0001, 2'd2};
        vecs[4]  = '{4'b0000,  1, 4'b0000, 4'b0100, 1'b0, 4'b0001, 2'd2};
        vecs[5]  = '{4'b0000,  1, 4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd2};
        vecs[6]  = '{4'b0000,  1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 2'd0};
        vecs[7]  = '{4'b0000, 10, 4'b0001, 4'b0000, 1'b0, 4'b0000, 2'd0};
        vecs[8]  = '{4'b0001,  0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 2'd0};
        vecs[9]  = '{4'b1111,  0, 4'b0001, 4'b0000, 1'b0, 4'b1110, 2'd0};
        vecs[10] = '{4'b0000,  1, 4'b0000, 4'b0001, 1'b0, 4'b1110, 2'd0};
        vecs[11] = '{4'b0000,  1, 4'b0000, 4'b0000, 1'b1, 4'b1110, 2'd0};
        vecs[12] = '{4'b0000,  1, 4'b0010, 4'b0000, 1'b0, 4'b1100, 2'd1};
        vecs[13] = '{4'b0000,  1, 4'b0010, 4'b0000, 1'b0, 4'b1100, 2'd1};
        vecs[14] = '{4'b0000,  1, 4'b0000, 4'b0010, 1'b0, 4'b1100, 2'd1};
        vecs[15] = '{4'b0000,  1, 4'b0000, 4'b0000, 1'b1, 4'b1100, 2'd1};
        vecs[16] = '{4'b0000,  1, 4'b0100, 4'b0000, 1'b0, 4'b1000, 2'd2};
        vecs[17] = '{4'b0000,  2, 4'b0000, 4'b0100, 1'b0, 4'b1000, 2'd2};
        vecs[18] = '{4'b0000,  2, 4'b1000, 4'b0000, 1'b0, 4'b0000, 2'd3};
        vecs[19] = '{4'b0000, 10, 4'b1000, 4'b0000, 1'b0, 4'b0000, 2'd3};

        $display("[TB] reset and idle");
        doReset();
        checkOutput("reset", 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd3);
        check4("reset", "tick", {3'b000, tick}, 4'b0000);
        checkFirstTick("first_tick");
        for (int i = 0; i < 20; i++) begin
            tickEdge();
            checkOutput($sformatf("idle_t%0d", i), 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd3);
        end

        $display("[TB] table sequence");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].rq, vecs[i].ticks);
            checkOutput($sformatf("vec%0d", i), vecs[i].g, vecs[i].y, vecs[i].ar,
                        vecs[i].p, vecs[i].ph);
        end

        $display("[TB] round robin from idle");
        doReset();
        ones = 4'b1111;
        applyStimulus(4'b1111, 1);
        for (int i = 0; i < 4; i++) begin
            oh = 4'b0001 << i;
            ep = ones << (i + 1);
            checkOutput($sformatf("rr%0d_g0", i), oh, 4'b0000, 1'b0, ep, 2'(i));
            tickEdge();
            checkOutput($sformatf("rr%0d_g1", i), oh, 4'b0000, 1'b0, ep, 2'(i));
            if (i < 3) begin
                tickEdge();
                checkOutput($sformatf("rr%0d_y", i), 4'b0000, oh, 1'b0, ep, 2'(i));
                tickEdge();
                checkOutput($sformatf("rr%0d_ar", i), 4'b0000, 4'b0000, 1'b1, ep, 2'(i));
                tickEdge();
            end
        end

        $display("[TB] maximum green and early release");
        doReset();
        req = 4'b0001;
        step();
        check4("max_pend", "pending", pending, 4'b0001);
        tickEdge();
        checkOutput("max_grant", 4'b0001, 4'b0000, 1'b0, 4'b0000, 2'd0);
        req = 4'b0011;
        step();
        req = 4'b0001;
        check4("max_comp", "pending", pending, 4'b0010);
        for (int t = 2; t <= 5; t++) begin
            tickEdge();
            checkOutput($sformatf("max_t%0d", t), 4'b0001, 4'b0000, 1'b0, 4'b0010, 2'd0);
        end
        tickEdge();
        checkOutput("max_yellow", 4'b0000, 4'b0001, 1'b0, 4'b0010, 2'd0);
        tickEdge();
        checkOutput("max_allred", 4'b0000, 4'b0000, 1'b1, 4'b0011, 2'd0);
        tickEdge();
        checkOutput("rel_grant", 4'b0010, 4'b0000, 1'b0, 4'b0001, 2'd1);
        req = 4'b0010;
        tickEdge();
        checkOutput("rel_t1", 4'b0010, 4'b0000, 1'b0, 4'b0001, 2'd1);
        tickEdge();
        checkOutput("rel_t2", 4'b0010, 4'b0000, 1'b0, 4'b0001, 2'd1);
        req = 4'b0000;
        tickEdge();
        checkOutput("rel_yellow", 4'b0000, 4'b0010, 1'b0, 4'b0001, 2'd1);

        $display("[TB] asynchronous reset during yellow");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd3);
        check4("async_rst", "tick", {3'b000, tick}, 4'b0000);
        repeat (2) step();
        reset = 1'b0;
        checkFirstTick("rst_tick");
        tickEdge();
        applyStimulus(4'b0100, 0);
        checkOutput("rst_pend", 4'b0000, 4'b0000, 1'b1, 4'b0100, 2'd3);
        applyStimulus(4'b0000, 1);
        checkOutput("rst_grant", 4'b0100, 4'b0000, 1'b0, 4'b0000, 2'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
